// File: rtl/qtcore_pkg.sv
// Shared definitions for the qtcore_a1 scan/run sequencer.
// Holds the sequencer state encoding, the command op codes, the scan chain
// length, and the chain field offsets so host-side code and RTL agree on
// where each core register sits in a scanned image.
package qtcore_pkg;

  localparam int QT_CHAIN_LEN = 160;

  // Scan image field offsets (bit 0 is the last bit to leave the chain).
  localparam int QT_STATE_LSB = 0;
  localparam int QT_STATE_MSB = 2;
  localparam int QT_PC_LSB    = 3;
  localparam int QT_PC_MSB    = 7;
  localparam int QT_IR_LSB    = 8;
  localparam int QT_IR_MSB    = 15;
  localparam int QT_ACC_LSB   = 16;
  localparam int QT_ACC_MSB   = 23;
  localparam int QT_MEM_BASE  = 24;
  localparam int QT_IO_LSB    = QT_CHAIN_LEN - 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_SHIFT, S_GAP, S_RUN, S_RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    OP_XCHG          = 2'd0,
    OP_RUN           = 2'd1,
    OP_XCHG_RUN_XCHG = 2'd2,
    OP_RSVD          = 2'd3
  } op_t;

  // LSB of memory byte i within a scan image.
  function automatic int mem_lsb(input int i);
    return QT_MEM_BASE + 8 * i;
  endfunction

  // State entered once any core reset pulse is done.
  function automatic seq_state_t first_state(input op_t op);
    return (op == OP_RUN) ? S_RUN : S_SHIFT;
  endfunction

endpackage

// File: rtl/qtcore_scan_shifter.sv
// Scan exchange shift register.
// load_in      : parallel-load sreg from load_data_in and restart the bit count
// shift_in     : shift one bit this cycle (MSB leaves, scan_q_in enters at LSB)
// scan_q_in    : core scan_out, captured on every shift
// sreg_out     : current register contents
// scan_data_out: bit presented to the core scan_in
// done_out     : high during the final shift of a full chain exchange
module qtcore_scan_shifter
  import qtcore_pkg::*;
#(
  parameter int CHAIN_LEN = QT_CHAIN_LEN
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 load_in,
  input  logic [CHAIN_LEN-1:0] load_data_in,
  input  logic                 shift_in,
  input  logic                 scan_q_in,
  output logic [CHAIN_LEN-1:0] sreg_out,
  output logic                 scan_data_out,
  output logic                 done_out
);

  localparam int CNT_W = $clog2(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] sreg;
  logic [CNT_W-1:0]     bit_cnt;

  assign done_out      = shift_in && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign sreg_out      = sreg;
  assign scan_data_out = sreg[CHAIN_LEN-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load_in) begin
      sreg    <= load_data_in;
      bit_cnt <= '0;
    end else if (shift_in) begin
      sreg    <= {sreg[CHAIN_LEN-2:0], scan_q_in};
      bit_cnt <= done_out ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/qtcore_scan_sequencer.sv
// Command-driven scan/run sequencer for the qtcore_a1 core.
// Host side : cmd_* request (valid/ready), rsp_* result (valid/ready),
//             load_data_in image to shift in, unload_data_out captured image.
// Core side : core_rst_out, core_scan_en_out, core_scan_data_out,
//             core_proc_en_out, core_scan_q_in (scan_out, or halt when not
//             scanning).
// An exchange swaps the whole chain: the core receives load_data_in while
// the old chain contents are captured. RUN enables the processor until halt
// or the cycle limit; XCHG_RUN_XCHG chains exchange, run and a second
// exchange (shifting zeros) to read back the result.
module qtcore_scan_sequencer
  import qtcore_pkg::*;
#(
  parameter int CHAIN_LEN = QT_CHAIN_LEN,
  parameter int CYC_W     = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 cmd_valid_in,
  output logic                 cmd_ready_out,
  input  logic [1:0]           cmd_op_in,
  input  logic                 cmd_core_rst_in,
  input  logic [CYC_W-1:0]     cmd_max_cycles_in,
  input  logic [CHAIN_LEN-1:0] load_data_in,
  output logic                 rsp_valid_out,
  input  logic                 rsp_ready_in,
  output logic                 rsp_halted_out,
  output logic [CYC_W-1:0]     rsp_cycles_out,
  output logic [CHAIN_LEN-1:0] unload_data_out,
  output logic                 core_rst_out,
  output logic                 core_scan_en_out,
  output logic                 core_scan_data_out,
  output logic                 core_proc_en_out,
  input  logic                 core_scan_q_in
);

  seq_state_t           state;
  op_t                  op_q;
  logic [CYC_W-1:0]     max_q;
  logic [CYC_W-1:0]     cnt_q;
  logic                 halted_q;
  logic                 second_q;   // XCHG_RUN_XCHG: run done, next exchange is the last
  logic [CHAIN_LEN-1:0] unload_q;

  logic                 sh_load, sh_done, sh_data;
  logic [CHAIN_LEN-1:0] sh_load_data, sreg;
  logic                 accept, halt_seen, run_exit, is_xrx;
  op_t                  cmd_op;

  // Reserved op code behaves as a plain exchange.
  assign cmd_op = (cmd_op_in == OP_RUN || cmd_op_in == OP_XCHG_RUN_XCHG)
                  ? op_t'(cmd_op_in) : OP_XCHG;

  assign accept    = cmd_valid_in && (state == S_IDLE);
  assign is_xrx    = (op_q == OP_XCHG_RUN_XCHG);
  // Halt is ignored for the first two run cycles while the core's scan_out
  // may still reflect stale chain data.
  assign halt_seen = (cnt_q >= CYC_W'(2)) && core_scan_q_in;
  assign run_exit  = (cnt_q == max_q) || halt_seen;

  // Second exchange of XCHG_RUN_XCHG shifts zeros in.
  assign sh_load      = accept || (state == S_RUN && run_exit && is_xrx);
  assign sh_load_data = (state == S_IDLE) ? load_data_in : '0;

  qtcore_scan_shifter #(.CHAIN_LEN(CHAIN_LEN)) u_shifter (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .load_in       (sh_load),
    .load_data_in  (sh_load_data),
    .shift_in      (state == S_SHIFT),
    .scan_q_in     (core_scan_q_in),
    .sreg_out      (sreg),
    .scan_data_out (sh_data),
    .done_out      (sh_done)
  );

  assign cmd_ready_out      = (state == S_IDLE);
  assign rsp_valid_out      = (state == S_RESP);
  assign rsp_halted_out     = halted_q;
  assign rsp_cycles_out     = cnt_q;
  assign unload_data_out    = unload_q;
  assign core_rst_out       = (state == S_CRST);
  assign core_scan_en_out   = (state == S_SHIFT);
  assign core_scan_data_out = (state == S_SHIFT) && sh_data;
  assign core_proc_en_out   = (state == S_RUN) && !run_exit;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      op_q     <= OP_XCHG;
      max_q    <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      second_q <= 1'b0;
      unload_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid_in) begin
          op_q     <= cmd_op;
          max_q    <= cmd_max_cycles_in;
          cnt_q    <= '0;
          halted_q <= 1'b0;
          second_q <= 1'b0;
          state    <= cmd_core_rst_in ? S_CRST : first_state(cmd_op);
        end
        S_CRST:  state <= first_state(op_q);
        S_SHIFT: if (sh_done) state <= S_GAP;
        S_GAP: begin
          if (is_xrx && !second_q) state <= S_RUN;
          else begin
            unload_q <= sreg;
            state    <= S_RESP;
          end
        end
        S_RUN: begin
          if (run_exit) begin
            halted_q <= halt_seen;
            if (is_xrx) begin
              second_q <= 1'b1;
              state    <= S_SHIFT;
            end else begin
              state <= S_RESP;
            end
          end else begin
            cnt_q <= cnt_q + CYC_W'(1);
          end
        end
        S_RESP:  if (rsp_ready_in) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
